// File: rtl/dds_phase_ctrl_if.sv
// Config port of dds_phase_ctrl. Each valid/ready transfer carries one frequency word
// or one phase-offset word, selected by cfg_sel.
interface dds_cfg_if #(
  parameter int ACC_W = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_sel;
  logic [ACC_W-1:0] cfg_data;

  modport master (output cfg_valid, cfg_sel, cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, cfg_sel, cfg_data, output cfg_ready);
endinterface

// File: rtl/dds_phase_ctrl.sv
// Phase accumulator front end for a registered sine ROM. Frequency and offset updates
// are staged, then committed at accumulator wrap. Stopping always lands on phase zero.
module dds_phase_ctrl #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 9,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  dds_cfg_if.slave          cfg,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              addr_valid,
  output logic              sample_valid,
  output logic              wrap,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP_WAIT} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   fword_q, fword_d;
  logic [ACC_W-1:0]   poff_q, poff_d;
  logic [ACC_W-1:0]   staged_f_q, staged_f_d;
  logic [ACC_W-1:0]   staged_p_q, staged_p_d;
  logic               pend_f_q, pend_f_d;
  logic               pend_p_q, pend_p_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               addr_valid_q, addr_valid_d;
  logic               wrap_q, wrap_d;
  logic [ROM_LAT-1:0] sv_q, sv_d;

  logic [ACC_W:0]     sum;
  logic               carry;
  logic               commit;
  logic               xfer;

  assign sum           = {1'b0, acc_q} + {1'b0, fword_q};
  assign carry         = (state_q != IDLE) && sum[ACC_W];
  assign cfg.cfg_ready = !pend_f_q && !pend_p_q;
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

  // NOTE: every always_comb output gets a default before any branch; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin : fsm_next
    state_d = state_q;
    acc_d   = sum[ACC_W-1:0];
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) state_d = STOP_WAIT;
      end
      STOP_WAIT: begin
        // A zero step can never carry, so stop immediately rather than wait forever.
        if (run) begin
          state_d = RUN;
        end else if (carry || fword_q == '0) begin
          state_d = IDLE;
          acc_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase
  end

  always_comb begin : cfg_next
    // The carry that ends a stop is not a wrap; its pending update commits from IDLE.
    wrap_d     = carry && (state_d != IDLE);
    commit     = (state_q == IDLE) || wrap_d;
    fword_d    = fword_q;
    poff_d     = poff_q;
    staged_f_d = staged_f_q;
    staged_p_d = staged_p_q;
    pend_f_d   = pend_f_q;
    pend_p_d   = pend_p_q;
    if (commit && pend_f_q) begin
      fword_d  = staged_f_q;
      pend_f_d = 1'b0;
    end
    if (commit && pend_p_q) begin
      poff_d   = staged_p_q;
      pend_p_d = 1'b0;
    end
    // xfer needs both pending flags clear, so it never collides with a commit above.
    if (xfer) begin
      if (cfg.cfg_sel) begin
        staged_p_d = cfg.cfg_data;
        pend_p_d   = 1'b1;
      end else begin
        staged_f_d = cfg.cfg_data;
        pend_f_d   = 1'b1;
      end
    end
  end

  // The address is built from next-state phase and offset so it lines up with addr_valid.
  assign rom_addr_d   = acc_d[ACC_W-1 -: ADDR_W] + poff_d[ACC_W-1 -: ADDR_W];
  assign addr_valid_d = (state_d != IDLE);

  always_comb begin : sv_next
    sv_d    = sv_q << 1;
    sv_d[0] = addr_valid_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      fword_q      <= '0;
      poff_q       <= '0;
      staged_f_q   <= '0;
      staged_p_q   <= '0;
      pend_f_q     <= 1'b0;
      pend_p_q     <= 1'b0;
      rom_addr_q   <= '0;
      addr_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      sv_q         <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fword_q      <= fword_d;
      poff_q       <= poff_d;
      staged_f_q   <= staged_f_d;
      staged_p_q   <= staged_p_d;
      pend_f_q     <= pend_f_d;
      pend_p_q     <= pend_p_d;
      rom_addr_q   <= rom_addr_d;
      addr_valid_q <= addr_valid_d;
      wrap_q       <= wrap_d;
      sv_q         <= sv_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign addr_valid   = addr_valid_q;
  assign sample_valid = sv_q[ROM_LAT-1];
  assign wrap         = wrap_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Bench for dds_phase_ctrl: directed steps along the intended use cases, then random
// run/config traffic, all compared cycle by cycle with a behavioural phase model.
module tb_dds_phase_ctrl;

  localparam int ACC_W   = 32;
  localparam int ADDR_W  = 9;
  localparam int ROM_LAT = 1;

  logic              clk;
  logic              rst_n;
  logic              run;
  logic [ADDR_W-1:0] rom_addr;
  logic              addr_valid;
  logic              sample_valid;
  logic              wrap;
  logic              busy;

  dds_cfg_if #(.ACC_W(ACC_W)) cfg_bus ();

  dds_phase_ctrl #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .cfg          (cfg_bus.slave),
    .rom_addr     (rom_addr),
    .addr_valid   (addr_valid),
    .sample_valid (sample_valid),
    .wrap         (wrap),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered sine ROM as the block would see it: offset binary, midscale at address 0.
  logic [11:0] rom [512];
  logic [11:0] rom_q;
  always @(posedge clk) rom_q <= rom[rom_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: mode 0 = idle, 1 = generating, 2 = stopping at next wrap.
  bit [31:0] m_acc, m_f, m_p, m_sf, m_sp;
  bit        m_pf, m_pp, m_av, m_wrap;
  bit        m_svd [ROM_LAT];
  int        m_mode;
  bit [8:0]  m_addr;

  task automatic model_reset();
    m_acc = 0; m_f = 0; m_p = 0; m_sf = 0; m_sp = 0;
    m_pf = 0; m_pp = 0; m_av = 0; m_wrap = 0; m_mode = 0; m_addr = 0;
    for (int i = 0; i < ROM_LAT; i++) m_svd[i] = 0;
  endtask

  task automatic model_step();
    bit [63:0] s;
    bit        overflow, wrapped, accept;
    int        nmode;
    bit [31:0] nacc;
    s        = 64'(m_acc) + 64'(m_f);
    overflow = (m_mode != 0) && (s >= 64'h1_0000_0000);
    accept   = cfg_bus.cfg_valid && !(m_pf || m_pp);
    nmode    = m_mode;
    nacc     = s[31:0];
    if (m_mode == 0) begin
      nacc  = 0;
      nmode = run ? 1 : 0;
    end else if (m_mode == 1) begin
      nmode = run ? 1 : 2;
    end else if (run) begin
      nmode = 1;
    end else if (overflow || m_f == 0) begin
      nmode = 0;
      nacc  = 0;
    end
    wrapped = overflow && (nmode != 0);
    if ((m_mode == 0) || wrapped) begin
      if (m_pf) begin m_f = m_sf; m_pf = 0; end
      if (m_pp) begin m_p = m_sp; m_pp = 0; end
    end
    if (accept) begin
      if (cfg_bus.cfg_sel) begin m_sp = cfg_bus.cfg_data; m_pp = 1; end
      else                 begin m_sf = cfg_bus.cfg_data; m_pf = 1; end
    end
    for (int i = ROM_LAT - 1; i > 0; i--) m_svd[i] = m_svd[i-1];
    m_svd[0] = m_av;
    m_av     = (nmode != 0);
    m_wrap   = wrapped;
    m_acc    = nacc;
    m_mode   = nmode;
    m_addr   = 9'((nacc >> 23) + (m_p >> 23));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("addr_valid", 32'(addr_valid), 32'(m_av));
    check("sample_valid", 32'(sample_valid), 32'(m_svd[ROM_LAT-1]));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(!(m_pf || m_pp)));
  endtask

  task automatic cfg_write(input bit sel, input bit [31:0] data);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_sel   = sel;
    cfg_bus.cfg_data  = data;
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  // Ticks until a wrap pulse is observed; returns the number of ticks, or -1 on timeout.
  task automatic ticks_to_wrap(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!wrap && n < limit);
    if (!wrap) n = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int        cnt, n, last, last_live;
    bit [31:0] d;
    for (int i = 0; i < 512; i++)
      rom[i] = 12'($rtoi(2047.0 + 2047.0 * $sin(2.0 * 3.14159265358979 * i / 512.0) + 0.5));

    run               = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_sel   = 1'b0;
    cfg_bus.cfg_data  = '0;
    rst_n             = 1'b0;
    model_reset();
    #23 rst_n = 1'b1;

    // Idle after reset.
    repeat (10) tick();
    check("idle_addr", 32'(rom_addr), 0);
    check("idle_addr_valid", 32'(addr_valid), 0);
    check("idle_sample_valid", 32'(sample_valid), 0);
    check("idle_wrap", 32'(wrap), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_ready", 32'(cfg_bus.cfg_ready), 1);

    // Step of one address per clock, loaded while idle.
    cfg_write(1'b0, 32'h0080_0000);
    check("idle_write_ready_low", 32'(cfg_bus.cfg_ready), 0);
    tick();
    check("idle_commit_ready", 32'(cfg_bus.cfg_ready), 1);
    run = 1'b1;
    tick();
    check("start_addr", 32'(rom_addr), 0);
    check("start_addr_valid", 32'(addr_valid), 1);
    check("start_sample_valid", 32'(sample_valid), 0);
    cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      last = int'(rom_addr);
      tick();
      cnt = (cnt + 1) % 512;
      check("ramp_addr", 32'(rom_addr), 32'(cnt));
      check("ramp_wrap", 32'(wrap), 32'(cnt == 0));
      if (i == 0) check("ramp_sample_valid_rise", 32'(sample_valid), 1);
      if (sample_valid && last == 0)   check("rom_midscale", 32'(rom_q), 32'h7FF);
      if (sample_valid && last == 128) check("rom_peak", 32'(rom_q), 32'hFFE);
    end

    // Phase offset of a quarter turn while running.
    cfg_write(1'b1, 32'h4000_0000);
    check("poff_pending_ready", 32'(cfg_bus.cfg_ready), 0);
    ticks_to_wrap(600, n);
    check("poff_wrap_seen", 32'(n > 0), 1);
    check("poff_addr_at_wrap", 32'(rom_addr), 128);
    tick();
    check("poff_addr_after", 32'(rom_addr), 129);
    check("poff_ready_back", 32'(cfg_bus.cfg_ready), 1);

    // Frequency change written on a carry cycle waits a full extra period.
    cfg_write(1'b0, 32'h0100_0000);
    ticks_to_wrap(600, n);
    check("f2_commit_wrap_seen", 32'(n > 0), 1);
    n = 0;
    while (m_acc != 32'hFF00_0000 && n < 300) begin
      tick();
      n++;
    end
    check("carry_align_found", 32'(m_acc), 32'hFF00_0000);
    cfg_write(1'b0, 32'h0080_0000);
    check("carry_write_wrap", 32'(wrap), 1);
    check("carry_write_pending", 32'(cfg_bus.cfg_ready), 0);
    ticks_to_wrap(1000, n);
    check("old_step_period", 32'(n), 256);
    check("late_commit_ready", 32'(cfg_bus.cfg_ready), 1);
    ticks_to_wrap(1000, n);
    check("new_step_period", 32'(n), 512);

    // Stop mid-period: run to the end of the cycle, land on phase zero, no wrap.
    n = 0;
    while ((m_acc >> 23) != 300 && n < 600) begin
      tick();
      n++;
    end
    check("stop_point_found", 32'(m_acc >> 23), 300);
    run       = 1'b0;
    last_live = -1;
    n         = 0;
    do begin
      tick();
      n++;
      check("stop_no_wrap", 32'(wrap), 0);
      if (addr_valid) last_live = int'(rom_addr);
    end while (busy && n < 600);
    check("stop_reached_idle", 32'(busy), 0);
    check("stop_last_live_addr", 32'(last_live), 32'((511 + 128) % 512));
    check("stop_addr_is_poff", 32'(rom_addr), 128);
    check("stop_addr_valid", 32'(addr_valid), 0);
    tick();
    check("stop_sample_valid", 32'(sample_valid), 0);

    // Random run/config traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(63) == 0) run = ~run;
      cfg_bus.cfg_valid = ($urandom_range(7) == 0);
      cfg_bus.cfg_sel   = $urandom_range(1);
      d                 = $urandom;
      cfg_bus.cfg_data  = ($urandom_range(5) == 0) ? 32'h0 : d;
      tick();
    end
    cfg_bus.cfg_valid = 1'b0;

    // Asynchronous reset mid-run, no clock edge in between.
    run = 1'b1;
    repeat (5) tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_addr", 32'(rom_addr), 0);
    check("async_rst_addr_valid", 32'(addr_valid), 0);
    check("async_rst_sample_valid", 32'(sample_valid), 0);
    check("async_rst_wrap", 32'(wrap), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_ready", 32'(cfg_bus.cfg_ready), 1);
    model_reset();
    #2 rst_n = 1'b1;
    repeat (4) tick();
    check("zero_step_addr", 32'(rom_addr), 0);
    check("zero_step_addr_valid", 32'(addr_valid), 1);
    run = 1'b0;
    tick();
    tick();
    check("zero_step_stop_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
